mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal around the fetch/memory-stage arbiter: pipeline requests, the shared memory port and the completion/stall outputs.
// master: the arbiter's view. It drives the shared memory port and the done/stall/status outputs.
// slave: the environment's view (pipeline plus memory). It drives the requests and the memory responses.
interface mem_port_arbiter_if;
    // fetch stage
    logic        f_req;
    logic [63:0] f_pc;
    logic        f_flush;
    logic        f_done;
    logic [79:0] f_instr;
    logic        f_stall;
    // memory stage
    logic        m_req;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic        m_done;
    logic [63:0] m_rdata;
    logic        m_stall;
    // shared memory port
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_valid;
    logic        mem_we;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;
    // status
    logic        adr_err;

    modport master (
        input  f_req, f_pc, f_flush, m_req, m_we, m_addr, m_wdata,
        input  mem_rdata, mem_ready, mem_err,
        output f_done, f_instr, f_stall, m_done, m_rdata, m_stall,
        output mem_addr, mem_wdata, mem_valid, mem_we, adr_err
    );

    modport slave (
        output f_req, f_pc, f_flush, m_req, m_we, m_addr, m_wdata,
        output mem_rdata, mem_ready, mem_err,
        input  f_done, f_instr, f_stall, m_done, m_rdata, m_stall,
        input  mem_addr, mem_wdata, mem_valid, mem_we, adr_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch (two beats, 10 bytes) and data access (one beat).
// Latency: m_done is registered and pulses 1 cycle after the grant at the earliest. f_done pulses 2 cycles after the grant at the earliest.
// Backpressure: f_stall and m_stall stay high until the matching done pulse. A memory error or a beat timeout halts the block until rst.
// Ports: clk and rst (synchronous, active-high). bus_io carries the requests, the shared memory port and the results.
module mem_port_arbiter #(
    parameter int TMO = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus_io
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_M_ACC    = 3'd1;
    localparam logic [2:0] S_F_B0     = 3'd2;
    localparam logic [2:0] S_F_B1     = 3'd3;
    localparam logic [2:0] S_HALT_ERR = 3'd4;

    localparam int CW = $clog2(TMO + 1);

    logic [2:0]    state_q,   state_d;
    logic [63:0]   pc_q,      pc_d;
    logic [63:0]   addr_q,    addr_d;
    logic [63:0]   wdata_q,   wdata_d;
    logic          we_q,      we_d;
    logic [63:0]   lo_q,      lo_d;
    logic          flush_q,   flush_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          f_done_q,  f_done_d;
    logic          m_done_q,  m_done_d;
    logic [79:0]   f_instr_q, f_instr_d;
    logic [63:0]   m_rdata_q, m_rdata_d;
    logic          adr_err_q, adr_err_d;

    logic in_beat;
    logic tmo_hit;
    logic beat_end;
    logic beat_err;
    logic flushed;
    logic halted;

    assign in_beat  = (state_q == S_M_ACC) || (state_q == S_F_B0) || (state_q == S_F_B1);
    assign halted   = (state_q == S_HALT_ERR);
    // The TMO-th cycle without mem_ready ends the beat as if memory had answered with an error.
    assign tmo_hit  = in_beat && !bus_io.mem_ready && (cnt_q == CW'(TMO - 1));
    assign beat_end = in_beat && (bus_io.mem_ready || tmo_hit);
    assign beat_err = beat_end && ((bus_io.mem_ready && bus_io.mem_err) || tmo_hit);
    // A flush can arrive on any cycle of a fetch beat, so it is remembered until the beat ends.
    assign flushed  = flush_q || bus_io.f_flush;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        lo_d      = lo_q;
        flush_d   = flush_q;
        f_instr_d = f_instr_q;
        m_rdata_d = m_rdata_q;
        adr_err_d = adr_err_q;
        f_done_d  = 1'b0;
        m_done_d  = 1'b0;
        // The count restarts at every beat entry: it is zero on leaving IDLE and after every beat end.
        cnt_d     = (in_beat && !beat_end) ? cnt_q + 1'b1 : '0;

        case (state_q)
            S_IDLE: begin
                flush_d = 1'b0;
                // A request whose done pulse is showing this cycle has already been served.
                // The requester drops it on this edge, so it must not be granted again.
                if (bus_io.m_req && !m_done_q) begin
                    state_d = S_M_ACC;
                    addr_d  = bus_io.m_addr;
                    wdata_d = bus_io.m_wdata;
                    we_d    = bus_io.m_we;
                end else if (bus_io.f_req && !bus_io.f_flush && !f_done_q) begin
                    state_d = S_F_B0;
                    pc_d    = bus_io.f_pc;
                end
            end
            S_M_ACC: begin
                if (beat_end) begin
                    m_done_d = 1'b1;
                    if (beat_err) begin
                        adr_err_d = 1'b1;
                        state_d   = S_HALT_ERR;
                    end else begin
                        if (!we_q) begin
                            m_rdata_d = bus_io.mem_rdata;
                        end
                        state_d = S_IDLE;
                    end
                end
            end
            S_F_B0: begin
                flush_d = beat_end ? 1'b0 : flushed;
                if (beat_end) begin
                    if (beat_err) begin
                        f_done_d  = 1'b1;
                        adr_err_d = 1'b1;
                        state_d   = S_HALT_ERR;
                    end else begin
                        lo_d    = bus_io.mem_rdata;
                        state_d = flushed ? S_IDLE : S_F_B1;
                    end
                end
            end
            S_F_B1: begin
                flush_d = beat_end ? 1'b0 : flushed;
                if (beat_end) begin
                    state_d = S_IDLE;
                    if (beat_err) begin
                        f_done_d  = 1'b1;
                        adr_err_d = 1'b1;
                        state_d   = S_HALT_ERR;
                    end else if (!flushed) begin
                        f_done_d  = 1'b1;
                        f_instr_d = {bus_io.mem_rdata[15:0], lo_q};
                    end
                end
            end
            default: begin
                // Only rst leaves HALT_ERR.
                state_d = S_HALT_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            lo_q      <= '0;
            flush_q   <= 1'b0;
            cnt_q     <= '0;
            f_done_q  <= 1'b0;
            m_done_q  <= 1'b0;
            f_instr_q <= '0;
            m_rdata_q <= '0;
            adr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            lo_q      <= lo_d;
            flush_q   <= flush_d;
            cnt_q     <= cnt_d;
            f_done_q  <= f_done_d;
            m_done_q  <= m_done_d;
            f_instr_q <= f_instr_d;
            m_rdata_q <= m_rdata_d;
            adr_err_q <= adr_err_d;
        end
    end

    // The port signals decode from registered state only, so they hold steady for the whole beat.
    always_comb begin
        bus_io.mem_addr = '0;
        case (state_q)
            S_M_ACC: bus_io.mem_addr = addr_q;
            S_F_B0:  bus_io.mem_addr = pc_q;
            S_F_B1:  bus_io.mem_addr = pc_q + 64'd8;
            default: bus_io.mem_addr = '0;
        endcase
    end

    assign bus_io.mem_valid = in_beat;
    assign bus_io.mem_we    = (state_q == S_M_ACC) && we_q;
    assign bus_io.mem_wdata = (state_q == S_M_ACC) ? wdata_q : '0;

    assign bus_io.f_done  = f_done_q;
    assign bus_io.m_done  = m_done_q;
    assign bus_io.f_instr = f_instr_q;
    assign bus_io.m_rdata = m_rdata_q;
    assign bus_io.adr_err = adr_err_q;
    assign bus_io.f_stall = halted || (bus_io.f_req && !f_done_q);
    assign bus_io.m_stall = halted || (bus_io.m_req && !m_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TMO(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
    } beat_t;

    int errors = 0;
    int checks = 0;

    logic [79:0] fq[$];
    logic [63:0] mq[$];
    beat_t       bq[$];
    logic [63:0] last_rd = '0;

    int lat         = 0;
    bit hold        = 1'b0;
    bit err_inj     = 1'b0;
    bit force_ready = 1'b0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F1E_2D3C_4B5A_6978;
    endfunction

    function automatic logic [79:0] exp_instr(input logic [63:0] pc);
        logic [63:0] lo;
        logic [63:0] hi;
        lo = rd(pc);
        hi = rd(pc + 64'd8);
        return {hi[15:0], lo};
    endfunction

    function automatic beat_t mk_beat(input logic [63:0] a, input logic w, input logic [63:0] d);
        beat_t b;
        b.addr  = a;
        b.we    = w;
        b.wdata = d;
        return b;
    endfunction

    // Memory responder: answers each beat after lat waiting cycles.
    // It checks that the port held still while waiting and that beats arrive in the expected order.
    int          wcnt = 0;
    logic [63:0] cap_addr, cap_wdata;
    logic        cap_we;
    always @(negedge clk) begin
        bus.mem_ready = 1'b0;
        bus.mem_err   = 1'b0;
        if (force_ready) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rd(64'd0);
        end else if (rst || !bus.mem_valid) begin
            wcnt = 0;
        end else begin
            if (wcnt == 0) begin
                cap_addr  = bus.mem_addr;
                cap_wdata = bus.mem_wdata;
                cap_we    = bus.mem_we;
            end
            if (!hold && wcnt >= lat) begin
                if (wcnt > 0) begin
                    chk("stable_addr", bus.mem_addr, cap_addr);
                    chk("stable_wdata", bus.mem_wdata, cap_wdata);
                    chk("stable_we", bus.mem_we, cap_we);
                end
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rd(bus.mem_addr);
                bus.mem_err   = err_inj;
                chk("beat_expected", bq.size() > 0, 1);
                if (bq.size() > 0) begin
                    beat_t b;
                    b = bq.pop_front();
                    chk("beat_addr", bus.mem_addr, b.addr);
                    chk("beat_we", bus.mem_we, b.we);
                    if (b.we) chk("beat_wdata", bus.mem_wdata, b.wdata);
                end
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
    end

    // Result scoreboard. Done pulses that come with an error are checked directly by the sequence.
    always @(negedge clk) begin
        if (!rst && !bus.adr_err) begin
            if (bus.f_done) begin
                chk("f_done_expected", fq.size() > 0, 1);
                if (fq.size() > 0) chk("f_instr", bus.f_instr, fq.pop_front());
            end
            if (bus.m_done) begin
                chk("m_done_expected", mq.size() > 0, 1);
                if (mq.size() > 0) chk("m_rdata", bus.m_rdata, mq.pop_front());
            end
        end
    end

    task automatic push_fetch(input logic [63:0] pc);
        bq.push_back(mk_beat(pc, 1'b0, '0));
        bq.push_back(mk_beat(pc + 64'd8, 1'b0, '0));
        fq.push_back(exp_instr(pc));
    endtask

    task automatic push_read(input logic [63:0] a);
        bq.push_back(mk_beat(a, 1'b0, '0));
        last_rd = rd(a);
        mq.push_back(last_rd);
    endtask

    task automatic push_write(input logic [63:0] a, input logic [63:0] d);
        bq.push_back(mk_beat(a, 1'b1, d));
        mq.push_back(last_rd);
    endtask

    task automatic wait_mdone(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.m_done && cyc < 60);
        chk(tag, bus.m_done, 1);
        bus.m_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_mem_valid"}, bus.mem_valid, 0);
        chk({pfx, "_mem_we"}, bus.mem_we, 0);
        chk({pfx, "_mem_addr"}, bus.mem_addr, 0);
        chk({pfx, "_f_done"}, bus.f_done, 0);
        chk({pfx, "_m_done"}, bus.m_done, 0);
        chk({pfx, "_adr_err"}, bus.adr_err, 0);
        chk({pfx, "_f_instr"}, bus.f_instr, 0);
        chk({pfx, "_m_rdata"}, bus.m_rdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, mcyc, fcyc, bad, nvalid;
        rst = 1'b1;
        bus.f_req = 1'b0; bus.f_pc = '0; bus.f_flush = 1'b0;
        bus.m_req = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0; bus.m_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0; bus.mem_err = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic fetch: f_done lands in the third cycle after the request.
        push_fetch(64'h100);
        bus.f_req = 1'b1; bus.f_pc = 64'h100;
        cyc = 0; bad = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!bus.f_done && !bus.f_stall) bad++;
        end while (!bus.f_done && cyc < 60);
        chk("fetch_latency", cyc, 3);
        chk("fetch_stall_held", bad, 0);
        chk("f_stall_at_done", bus.f_stall, 0);
        bus.f_req = 1'b0;
        @(negedge clk);

        // Simultaneous requests: the data access goes first, then the fetch.
        push_read(64'h200);
        push_fetch(64'h300);
        bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_addr = 64'h200;
        bus.f_req = 1'b1; bus.f_pc = 64'h300;
        cyc = 0; bad = 0; mcyc = 0; fcyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.m_done) begin mcyc = cyc; bus.m_req = 1'b0; end
            if (bus.f_done) fcyc = cyc;
            else if (!bus.f_stall) bad++;
        end while (!bus.f_done && cyc < 60);
        chk("both_m_done_cycle", mcyc, 2);
        chk("both_f_done_cycle", fcyc, 5);
        chk("both_f_stall_held", bad, 0);
        bus.f_req = 1'b0;
        @(negedge clk);

        // A write arriving during F_B0 waits for both fetch beats. Slow memory exercises beat stability.
        lat = 2;
        push_fetch(64'h400);
        push_write(64'h500, 64'hDEAD_BEEF_0123_4567);
        bus.f_req = 1'b1; bus.f_pc = 64'h400;
        cyc = 0; mcyc = 0; fcyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_addr = 64'h500; bus.m_wdata = 64'hDEAD_BEEF_0123_4567;
            end
            if (bus.f_done) begin fcyc = cyc; bus.f_req = 1'b0; end
            if (bus.m_done) mcyc = cyc;
        end while (!bus.m_done && cyc < 80);
        chk("write_done_seen", bus.m_done, 1);
        chk("write_after_fetch", (fcyc > 0) && (mcyc > fcyc), 1);
        bus.m_req = 1'b0; bus.m_we = 1'b0; bus.f_req = 1'b0;
        lat = 0;
        @(negedge clk);

        // Flush during F_B1: the beat finishes, there is no f_done, and the next cycle is IDLE.
        bq.push_back(mk_beat(64'h600, 1'b0, '0));
        bq.push_back(mk_beat(64'h608, 1'b0, '0));
        bus.f_req = 1'b1; bus.f_pc = 64'h600;
        @(negedge clk);
        @(negedge clk);
        chk("flush_b1_addr", bus.mem_addr, 64'h608);
        bus.f_flush = 1'b1; bus.f_req = 1'b0;
        @(negedge clk);
        chk("flush_b1_no_done", bus.f_done, 0);
        chk("flush_b1_idle", bus.mem_valid, 0);
        bus.f_flush = 1'b0;
        @(negedge clk);

        // Flush during F_B0: F_B1 is skipped.
        bq.push_back(mk_beat(64'h700, 1'b0, '0));
        bus.f_req = 1'b1; bus.f_pc = 64'h700;
        @(negedge clk);
        chk("flush_b0_addr", bus.mem_addr, 64'h700);
        bus.f_flush = 1'b1; bus.f_req = 1'b0;
        @(negedge clk);
        chk("flush_b0_idle", bus.mem_valid, 0);
        bus.f_flush = 1'b0;
        @(negedge clk);
        chk("flush_b0_no_done", bus.f_done, 0);
        chk("flush_b0_still_idle", bus.mem_valid, 0);

        // mem_err on F_B0: adr_err, f_done pulse, halt without entering F_B1.
        err_inj = 1'b1;
        bq.push_back(mk_beat(64'h800, 1'b0, '0));
        bus.f_req = 1'b1; bus.f_pc = 64'h800;
        @(negedge clk);
        @(negedge clk);
        chk("err_f_done", bus.f_done, 1);
        chk("err_adr_err", bus.adr_err, 1);
        chk("err_mem_valid", bus.mem_valid, 0);
        chk("err_f_stall", bus.f_stall, 1);
        bus.f_req = 1'b0; err_inj = 1'b0;
        @(negedge clk);
        chk("halt_f_done_pulse", bus.f_done, 0);
        chk("halt_adr_err_sticky", bus.adr_err, 1);
        chk("halt_m_stall", bus.m_stall, 1);
        bus.m_req = 1'b1; bus.m_addr = 64'h900;
        @(negedge clk);
        chk("halt_no_grant", bus.mem_valid, 0);
        bus.m_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; last_rd = '0;
        check_reset_outputs("rst_after_err");

        // Timeout: sixteen cycles without mem_ready end the access with an error.
        hold = 1'b1;
        bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_addr = 64'hA00;
        cyc = 0; nvalid = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.mem_valid) nvalid++;
        end while (!bus.adr_err && cyc < 60);
        chk("tmo_cycle", cyc, 17);
        chk("tmo_valid_cycles", nvalid, 16);
        chk("tmo_m_done", bus.m_done, 1);
        chk("tmo_mem_valid", bus.mem_valid, 0);
        bus.m_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_after_tmo");

        // Reset mid-beat, then a stray mem_ready in IDLE must be ignored.
        bus.m_req = 1'b1; bus.m_addr = 64'hB00;
        repeat (3) @(negedge clk);
        chk("midbeat_valid", bus.mem_valid, 1);
        rst = 1'b1; bus.m_req = 1'b0;
        @(negedge clk);
        chk("midbeat_abandon", bus.mem_valid, 0);
        rst = 1'b0; hold = 1'b0; force_ready = 1'b1;
        @(negedge clk);
        chk("late_ready_no_done_a", bus.m_done, 0);
        force_ready = 1'b0;
        @(negedge clk);
        chk("late_ready_no_done_b", bus.m_done, 0);
        chk("late_ready_idle", bus.mem_valid, 0);

        // Normal traffic after recovery: a read with one wait cycle, then a write that leaves m_rdata alone.
        lat = 1;
        push_read(64'hC00);
        bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_addr = 64'hC00;
        wait_mdone("read_done_seen", cyc);
        chk("read_latency", cyc, 3);
        lat = 0;
        @(negedge clk);
        push_write(64'hC08, 64'h0123_4567_89AB_CDEF);
        bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_addr = 64'hC08; bus.m_wdata = 64'h0123_4567_89AB_CDEF;
        wait_mdone("write2_done_seen", cyc);
        chk("write2_latency", cyc, 2);
        bus.m_we = 1'b0;
        repeat (2) @(negedge clk);

        chk("fq_drained", fq.size(), 0);
        chk("mq_drained", mq.size(), 0);
        chk("bq_drained", bq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
